// File: rtl/fnd_pkg.sv
// Shared definitions for the FND display path.
// Holds the segment encodings, the special digit codes, the digit-enable
// table, the FSM state type and fnd_dec, the BCD to 7-segment encoder that
// the transmit side uses and that the receive side inverts.
package fnd_pkg;

  localparam int DIGITS = 6;

  // {a..g}, active-high
  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h73;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam logic [3:0] CODE_ILL   = 4'hE;

  // Active-low one-hot digit enables; entry k selects digit k.
  localparam logic [DIGITS-1:0] ENB_ALL_OFF = 6'h3F;
  localparam logic [DIGITS-1:0] ENB_ONEHOT [DIGITS] = '{
    6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111
  };

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  function automatic logic [6:0] fnd_dec(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_to_bcd.sv
// Inverse of fnd_dec: 7-segment pattern back to a digit code.
// Ports:
//   seg  in  7  {a..g}, active-high
//   bcd  out 4  0-9, CODE_BLANK for all segments off, CODE_ILL otherwise
//   ill  out 1  pattern is neither a digit nor blank
module seg_to_bcd
  import fnd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       ill
);

  // Searching the encoder's own table keeps the two directions consistent.
  always_comb begin
    bcd = CODE_ILL;
    ill = 1'b1;
    if (seg == SEG_BLANK) begin
      bcd = CODE_BLANK;
      ill = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (seg == fnd_dec(4'(i))) begin
        bcd = 4'(i);
        ill = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fnd_scan_rx.sv
// Receiver for the multiplexed 6-digit FND bus. Synchronises the bus, waits
// for each digit slot to settle, samples it once, decodes it back to BCD and
// rebuilds whole d0..d5 frames. Also reports illegal patterns, out-of-order
// scans and a stalled scan.
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous reset, active-low
//   i_seg          in   7   {a..g}, active-high, asynchronous
//   i_seg_dp       in   1   decimal point of the enabled digit
//   i_seg_enb      in   6   digit enables, active-low one-hot
//   o_digits       out  24  {d5..d0}: 0-9, F blank, E illegal
//   o_dp           out  6   captured decimal points
//   o_sec          out  6   d1*10+d0
//   o_min          out  6   d3*10+d2
//   o_frame_valid  out  1   pulse when the outputs above update
//   o_err          out  1   pulse on illegal enable/pattern or out-of-order digit
//   o_stale        out  1   scan stalled, or no frame since reset
//
// state      | meaning
// ST_HUNT    | waiting for a digit-0 sample to start a frame
// ST_COLLECT | digits 0..exp_idx-1 are in the shadow, expecting exp_idx
// ST_COMMIT  | digit 5 stored, shadow moves to the outputs this cycle
module fnd_scan_rx
  import fnd_pkg::*;
#(
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  i_seg,
  input  logic        i_seg_dp,
  input  logic [5:0]  i_seg_enb,
  output logic [23:0] o_digits,
  output logic [5:0]  o_dp,
  output logic [5:0]  o_sec,
  output logic [5:0]  o_min,
  output logic        o_frame_valid,
  output logic        o_err,
  output logic        o_stale
);

  localparam int STAB_W = $clog2(SETTLE_CYC + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(SETTLE_CYC);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);
  localparam logic [13:0] BUS_IDLE = {ENB_ALL_OFF, 1'b0, SEG_BLANK};

  // bus = {enb, dp, seg}
  logic [13:0] sync_1, sync_2, bus_prev;
  logic [5:0]  enb;
  logic        dp;
  logic [6:0]  seg;
  logic        any_change, enb_change;

  logic [STAB_W-1:0] stab_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              slot_done;
  logic              sample, samp_ok, samp_bad, timeout_now;

  logic       enb_legal;
  logic [2:0] idx;
  logic [3:0] seg_bcd;
  logic       seg_ill;

  state_t     state, state_nxt;
  logic [2:0] exp_idx, exp_nxt;
  logic       store_en, commit, seq_err;

  logic [3:0] sh_digit [DIGITS];
  logic [5:0] sh_dp;
  logic [6:0] sec_full, min_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1   <= BUS_IDLE;
      sync_2   <= BUS_IDLE;
      bus_prev <= BUS_IDLE;
    end else begin
      sync_1   <= {i_seg_enb, i_seg_dp, i_seg};
      sync_2   <= sync_1;
      bus_prev <= sync_2;
    end
  end

  assign enb        = sync_2[13:8];
  assign dp         = sync_2[7];
  assign seg        = sync_2[6:0];
  assign any_change = (sync_2 != bus_prev);
  assign enb_change = (sync_2[13:8] != bus_prev[13:8]);

  // slot_done keeps a slot to one sample even if seg glitches after it.
  assign sample = !any_change && !slot_done && (stab_cnt == STAB_MAX - STAB_W'(1))
                  && (enb != ENB_ALL_OFF);
  assign samp_ok  = sample && enb_legal;
  assign samp_bad = sample && !enb_legal;

  // An enable change in the saturating cycle wins over the timeout.
  assign timeout_now = !enb_change && (idle_cnt >= IDLE_MAX - IDLE_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt  <= '0;
      idle_cnt  <= '0;
      slot_done <= 1'b0;
    end else begin
      if (any_change)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + STAB_W'(1);

      if (enb_change)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + IDLE_W'(1);

      if (enb_change)
        slot_done <= 1'b0;
      else if (sample)
        slot_done <= 1'b1;
    end
  end

  always_comb begin
    enb_legal = 1'b0;
    idx       = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (enb == ENB_ONEHOT[i]) begin
        enb_legal = 1'b1;
        idx       = 3'(i);
      end
    end
  end

  seg_to_bcd u_seg_to_bcd (
    .seg (seg),
    .bcd (seg_bcd),
    .ill (seg_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_HUNT;
      exp_idx <= 3'd0;
    end else begin
      state   <= state_nxt;
      exp_idx <= exp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_idx;
    case (state)
      ST_HUNT: begin
        if (samp_ok && idx == 3'd0) begin
          state_nxt = ST_COLLECT;
          exp_nxt   = 3'd1;
        end
      end
      ST_COLLECT: begin
        if (samp_bad) begin
          state_nxt = ST_HUNT;
          exp_nxt   = 3'd0;
        end else if (samp_ok) begin
          if (idx == exp_idx) begin
            if (exp_idx == 3'd5) begin
              state_nxt = ST_COMMIT;
              exp_nxt   = 3'd0;
            end else begin
              exp_nxt = exp_idx + 3'd1;
            end
          end else if (idx == 3'd0) begin
            exp_nxt = 3'd1;
          end else begin
            state_nxt = ST_HUNT;
            exp_nxt   = 3'd0;
          end
        end
      end
      default: begin
        state_nxt = ST_HUNT;
        exp_nxt   = 3'd0;
      end
    endcase
    if (timeout_now && state != ST_COMMIT) begin
      state_nxt = ST_HUNT;
      exp_nxt   = 3'd0;
    end
  end

  always_comb begin
    store_en = 1'b0;
    commit   = 1'b0;
    seq_err  = 1'b0;
    case (state)
      ST_HUNT:    store_en = samp_ok && (idx == 3'd0) && !timeout_now;
      ST_COLLECT: begin
        if (samp_ok && !timeout_now) begin
          store_en = (idx == exp_idx) || (idx == 3'd0);
          seq_err  = (idx != exp_idx);
        end
      end
      default:    commit = 1'b1;
    endcase
  end

  // Only digits 0..9 contribute; blank and illegal count as zero.
  function automatic logic [6:0] code_val(input logic [3:0] c);
    return (c <= 4'd9) ? {3'b000, c} : 7'd0;
  endfunction

  assign sec_full = code_val(sh_digit[1]) * 7'd10 + code_val(sh_digit[0]);
  assign min_full = code_val(sh_digit[3]) * 7'd10 + code_val(sh_digit[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) sh_digit[i] <= CODE_BLANK;
      sh_dp <= '0;
    end else if (store_en) begin
      sh_digit[idx] <= seg_bcd;
      sh_dp[idx]    <= dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_digits      <= 24'hFFFFFF;
      o_dp          <= '0;
      o_sec         <= '0;
      o_min         <= '0;
      o_frame_valid <= 1'b0;
      o_err         <= 1'b0;
      o_stale       <= 1'b1;
    end else begin
      o_frame_valid <= commit;
      o_err         <= samp_bad || (samp_ok && seg_ill) || seq_err;
      if (commit) begin
        o_digits <= {sh_digit[5], sh_digit[4], sh_digit[3],
                     sh_digit[2], sh_digit[1], sh_digit[0]};
        o_dp     <= sh_dp;
        o_sec    <= 6'(sec_full);
        o_min    <= 6'(min_full);
      end
      if (timeout_now)
        o_stale <= 1'b1;
      else if (commit)
        o_stale <= 1'b0;
    end
  end

endmodule
